// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu
// over a fixed Busy latency and serves mthi/mtlo writes and mfhi/mflo reads.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWe,
  input  logic        LOWe,
  input  logic        ReadHI,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_div0;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_divs_b;
  logic [31:0] w_divu_b;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;
  logic        w_b_zero;
  logic        w_div_ovf;
  logic [63:0] w_result;

  assign w_b_zero  = (B == 32'd0);
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Dividing by 1 instead of -1 in the overflow case yields exactly
  // quotient=A=0x80000000, remainder=0; zero divisors are likewise replaced
  // so the dividers never see an undefined operand.
  assign w_divs_b = (w_b_zero || w_div_ovf) ? 32'd1 : B;
  assign w_divu_b = w_b_zero ? 32'd1 : B;

  assign w_prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_quot_s = 32'($signed(A) / $signed(w_divs_b));
  assign w_rem_s  = 32'($signed(A) % $signed(w_divs_b));
  assign w_quot_u = A / w_divu_b;
  assign w_rem_u  = A % w_divu_b;

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_result = w_prod_s;
    unique case (MDOp)
      2'b00: w_result = w_prod_s;
      2'b01: w_result = w_prod_u;
      2'b10: w_result = {w_rem_s, w_quot_s};
      2'b11: w_result = {w_rem_u, w_quot_u};
      default: w_result = w_prod_s;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // pending result registers are reset along with HI/LO so an aborted
  // operation can never leak a stale value into HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_phi   <= w_result[63:32];
            r_plo   <= w_result[31:0];
            r_div0  <= MDOp[1] && w_b_zero;
            r_cnt   <= MDOp[1] ? DIV_N : MULT_N;
            r_state <= S_RUN;
          end else begin
            if (HIWe) r_hi <= A;
            if (LOWe) r_lo <= A;
          end
        end
        S_RUN: begin
          // Start, HIWe and LOWe are deliberately ignored while running.
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
            if (!r_div0) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state == S_RUN);
  assign Out  = ReadHI ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: reset/abort, a table of mult/div vectors scored
// through an expected-result queue, and the mthi/mtlo-vs-Busy corner cases.
module tb_mdu;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWe;
  logic        LOWe;
  logic        ReadHI;
  logic        Busy;
  logic [31:0] Out;

  mdu #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .HIWe  (HIWe),
    .LOWe  (LOWe),
    .ReadHI(ReadHI),
    .Busy  (Busy),
    .Out   (Out)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    ReadHI = 1'b0;
    #1 lo = Out;
    ReadHI = 1'b1;
    #1 hi = Out;
    ReadHI = 1'b0;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    logic [31:0] hi, lo;
    read_hilo(hi, lo);
    check({name, " HI"}, {32'd0, hi}, {32'd0, hi_exp});
    check({name, " LO"}, {32'd0, lo}, {32'd0, lo_exp});
  endtask

  // Counts negedges at which Busy is high; bounded so a stuck Busy still ends.
  task automatic wait_busy_low(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt_write(input logic hi_we, input logic lo_we, input logic [31:0] val);
    @(negedge clk);
    HIWe = hi_we;
    LOWe = lo_we;
    A    = val;
    @(negedge clk);
    HIWe = 1'b0;
    LOWe = 1'b0;
  endtask

  task automatic run_op(input int idx, input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    Start = 1'b1;
    MDOp  = v.op;
    A     = v.a;
    B     = v.b;
    sb_q.push_back('{hi: v.hi, lo: v.lo, cycles: (v.op[1] ? DIV_CYCLES : MULT_CYCLES)});
    @(negedge clk);
    Start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    wait_busy_low(n);
    e = sb_q.pop_front();
    check($sformatf("vec%0d busy cycles", idx), 64'(n), 64'(e.cycles));
    check_hilo($sformatf("vec%0d", idx), e.hi, e.lo);
  endtask

  initial begin
    exp_t e;
    int   n;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5]  = '{2'b11, 32'd55,        32'd0,         32'd2,         32'd14};
    vecs[6]  = '{2'b00, 32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{2'b10, 32'd5,         32'd0,         32'h0000_0001, 32'h0000_0000};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};

    reset  = 1'b0;
    Start  = 1'b0;
    MDOp   = 2'b00;
    A      = 32'd0;
    B      = 32'd0;
    HIWe   = 1'b0;
    LOWe   = 1'b0;
    ReadHI = 1'b0;

    // Reset state, then abort a running mult with reset at busy cycle 2.
    repeat (2) @(negedge clk);
    check("reset Busy", {63'd0, Busy}, 64'd0);
    check_hilo("reset", 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    Start = 1'b1;
    MDOp  = 2'b00;
    A     = 32'd3;
    B     = 32'd4;
    @(negedge clk);
    Start = 1'b0;
    check("abort busy c1", {63'd0, Busy}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort Busy async", {63'd0, Busy}, 64'd0);
    check_hilo("abort during reset", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort Busy after", {63'd0, Busy}, 64'd0);
    check_hilo("abort after release", 32'd0, 32'd0);

    // mthi+mtlo together, then separate preload.
    mt_write(1'b1, 1'b1, 32'h0000_0033);
    check_hilo("mthi+mtlo", 32'h33, 32'h33);
    mt_write(1'b1, 1'b0, 32'h0000_0011);
    mt_write(1'b0, 1'b1, 32'h0000_0022);
    check_hilo("preload", 32'h11, 32'h22);

    for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

    // mult 2*3 with an illegal Start at busy cycle 2 and mthi at busy cycle 3.
    @(negedge clk);
    Start = 1'b1;
    MDOp  = 2'b00;
    A     = 32'd2;
    B     = 32'd3;
    sb_q.push_back('{hi: 32'd0, lo: 32'd6, cycles: MULT_CYCLES});
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      Start = (n == 2);
      MDOp  = 2'b11;
      A     = (n == 3) ? 32'h0000_DEAD : ((n == 2) ? 32'd100 : 32'd0);
      B     = 32'd7;
      HIWe  = (n == 3);
      @(negedge clk);
    end
    Start = 1'b0;
    HIWe  = 1'b0;
    e = sb_q.pop_front();
    check("hazard busy cycles", 64'(n), 64'(e.cycles));
    check_hilo("hazard result", e.hi, e.lo);
    check("hazard Busy idle", {63'd0, Busy}, 64'd0);

    mt_write(1'b1, 1'b0, 32'h0000_BEEF);
    check_hilo("mthi idle", 32'h0000_BEEF, 32'd6);

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the pipelined MIPS core; sits in the E stage beside the ALU.
- Receives the `Start` pulse for mult/multu/div/divu and raises `Busy` for a fixed latency. The hazard unit samples `Start` and `Busy` and stalls any D-stage md instruction while either is high.
- Owns the HI/LO registers and serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  one-cycle pulse while a mult/multu/div/divu instruction is in E.
- MDOp  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled only when Start=1.
- A  in  32  rs operand after E-stage forwarding.
- B  in  32  rt operand after E-stage forwarding.
- HIWe  in  1  mthi in E: HI <= A.
- LOWe  in  1  mtlo in E: LO <= A.
- ReadHI  in  1  1 selects HI onto Out, 0 selects LO (mfhi/mflo).
- Busy  out  1  operation in progress.
- Out  out  32  combinational ReadHI ? HI : LO.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, pending result registers=0. Out=0 follows.
- Reset asserted mid-operation aborts it. The pending result is discarded and HI/LO are not updated.
- Idle: Busy=0, counter=0.
- Start=1 at edge t0 while Busy=0:
  - Latch MDOp, A and B.
  - Compute the 64-bit result into pending registers {pHI, pLO}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from t0.
- Busy phase: counter decrements each edge.
  - The edge at which the counter goes 1 -> 0 writes HI=pHI and LO=pLO, and Busy=0 in the same edge.
  - Busy is therefore high for exactly N cycles. New HI/LO are visible on Out in the cycle after Busy falls.
- State machine:
  - IDLE -> RUN on Start.
  - RUN -> IDLE when the counter expires.
  - Any state -> IDLE on reset.
- mult: {HI,LO} = signed A * signed B, 64-bit.
- multu: {HI,LO} = unsigned A * unsigned B, 64-bit.
- div (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend A.
  - Overflow case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: LO = A / B, HI = A % B, unsigned.
- Divide by zero (B=0, div or divu): full DIV_CYCLES latency still runs; HI and LO are left unchanged at completion.
- HIWe/LOWe: write on the next edge only when Busy=0 and Start=0.
  - HIWe and LOWe in the same cycle writes both from A.
  - Ignored when Busy=1 or Start=1. The hazard unit guarantees this cannot happen legally; the ignore is a defensive rule.
- Start while Busy=1: ignored (illegal under correct stalling). The running operation continues unaffected.
- Out is purely combinational from HI/LO. During Busy it shows the old values; the hazard unit stalls mfhi/mflo, so the stale value is never consumed.

Test Plan:
- Reset: deassert reset, Start with MDOp=00, A=3, B=4; assert reset at busy cycle 2 → Busy=0 immediately, HI=LO=0, and they remain 0 after release.
- mult signed: A=0xFFFFFFFE (-2), B=3, Start at t0 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; Out shows LO with ReadHI=0 and HI with ReadHI=1.
- multu: A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div signed and overflow:
  - A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu and divide by zero:
  - Preload HI=0x11, LO=0x22 via mthi/mtlo.
  - divu A=100, B=7 → HI=2, LO=14.
  - Then divu B=0 → Busy 10 cycles; HI=2, LO=14 unchanged.
- mthi/mtlo vs Busy: start mult 2*3; pulse HIWe with A=0xDEAD during busy cycle 3 → ignored, final HI=0, LO=6. Then HIWe with A=0xBEEF while idle → HI=0xBEEF on the next cycle.
